lfsr10_checker: RTL and testbench

//  Receive-side checker for the 10-bit LFSR pattern generator (polynomial x^10+x^7+1).

---
 rtl/lfsr10_checker.sv | 136 +++++++++++++
 tb/tb_lfsr10_checker.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr10_checker.sv
// Receive-side checker for the x^10+x^7+1 LFSR pattern: self-synchronises, locks, flywheels, counts errors.
// Define LFSR_CHK_BITERR_EN to count bit errors (popcount of the mismatch) instead of word errors.
module lfsr10_checker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       data_in,
  input  logic             data_valid,
  output logic             locked,
  output logic [1:0]       sync_state,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W  = $clog2(LOSS_CNT + 1);
  localparam int unsigned SUM_W   = CNT_W + 4;
  localparam logic [SUM_W-1:0] CNT_MAX = {4'b0000, {CNT_W{1'b1}}};

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state_q;
  logic [9:0]         exp_q;
  logic [MATCH_W-1:0] match_q;
  logic [MISS_W-1:0]  miss_q;

  logic [3:0]         err_inc_c;
  logic [SUM_W-1:0]   err_sum_c;
  logic [CNT_W-1:0]   err_next_c;
  logic               word_ok_c;
  logic               seed_ok_c;
  logic               match_done_c;
  logic               miss_done_c;

  function automatic logic [9:0] lfsr_next(input logic [9:0] s);
    return {s[8:0], s[9] ^ s[6]};
  endfunction

  function automatic logic [3:0] popcount10(input logic [9:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 10; i++) c = c + 4'(v[i]);
    return c;
  endfunction

  assign sync_state = state_q;

  // Error increment and saturating accumulate
  always_comb begin
`ifdef LFSR_CHK_BITERR_EN
    err_inc_c = popcount10(data_in ^ exp_q);
`else
    err_inc_c = 4'd1;
`endif
    err_sum_c  = SUM_W'(err_count) + SUM_W'(err_inc_c);
    err_next_c = (err_sum_c > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : err_sum_c[CNT_W-1:0];
  end

  assign word_ok_c    = (data_in == exp_q);
  assign seed_ok_c    = (data_in != 10'd0);
  assign match_done_c = (match_q == MATCH_W'(LOCK_CNT - 1));
  assign miss_done_c  = (miss_q == MISS_W'(LOSS_CNT - 1));

  // Sync state machine, flywheel LFSR and error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SEARCH;
      exp_q     <= 10'd0;
      match_q   <= '0;
      miss_q    <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (data_valid) begin
        case (state_q)
          SEARCH: begin
            if (seed_ok_c) begin
              exp_q   <= lfsr_next(data_in);
              match_q <= '0;
              state_q <= VERIFY;
            end
          end
          VERIFY: begin
            if (word_ok_c) begin
              exp_q <= lfsr_next(exp_q);
              if (match_done_c) begin
                match_q <= '0;
                miss_q  <= '0;
                state_q <= LOCKED;
                locked  <= 1'b1;
              end else begin
                match_q <= match_q + MATCH_W'(1);
              end
            end else if (seed_ok_c) begin
              exp_q   <= lfsr_next(data_in);
              match_q <= '0;
            end else begin
              match_q <= '0;
              state_q <= SEARCH;
            end
          end
          LOCKED: begin
            exp_q <= lfsr_next(exp_q);
            if (word_ok_c) begin
              miss_q <= '0;
            end else begin
              err_pulse <= 1'b1;
              err_count <= err_next_c;
              if (miss_done_c) begin
                miss_q  <= '0;
                state_q <= SEARCH;
                locked  <= 1'b0;
              end else begin
                miss_q <= miss_q + MISS_W'(1);
              end
            end
          end
          default: begin
            state_q <= SEARCH;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr10_checker.sv
// Bench for lfsr10_checker: vector table, directed corner sequences and a random stream vs a reference model.
module tb_lfsr10_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_valid = 1'b0;
  logic [9:0] data_in = 10'd0;

  logic       locked_a, err_pulse_a, locked_b, err_pulse_b;
  logic [1:0] st_a, st_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  lfsr10_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .locked(locked_a), .sync_state(st_a), .err_pulse(err_pulse_a), .err_count(cnt_a));

  lfsr10_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .locked(locked_b), .sync_state(st_b), .err_pulse(err_pulse_b), .err_count(cnt_b));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model, one slot per instance
  int m_st[2], m_exp[2], m_match[2], m_miss[2], m_cnt[2], m_pulse[2];
  int m_max[2];

  logic [9:0] gen;

  typedef struct {
    logic       r;
    logic       v;
    logic [9:0] d;
    int         st;
    int         lk;
    int         ep;
    int         cnt;
  } vec_t;
  vec_t tbl[12];

  function automatic int nx(input int s);
    return ((s << 1) & 32'h3fe) | (((s >> 9) ^ (s >> 6)) & 1);
  endfunction

  function automatic int pop(input int v);
    int c = 0;
    for (int i = 0; i < 10; i++) c += (v >> i) & 1;
    return c;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_step(input int k);
    int d, e, inc;
    d = int'(data_in);
    if (rst) begin
      m_st[k] = 0; m_exp[k] = 0; m_match[k] = 0; m_miss[k] = 0;
      m_cnt[k] = 0; m_pulse[k] = 0;
      return;
    end
    m_pulse[k] = 0;
    if (!data_valid) return;
    if (m_st[k] == 0) begin
      if (d != 0) begin m_exp[k] = nx(d); m_match[k] = 0; m_st[k] = 1; end
    end else if (m_st[k] == 1) begin
      if (d == m_exp[k]) begin
        m_exp[k] = nx(m_exp[k]);
        m_match[k]++;
        if (m_match[k] == 4) begin m_st[k] = 2; m_match[k] = 0; m_miss[k] = 0; end
      end else if (d != 0) begin
        m_exp[k] = nx(d); m_match[k] = 0;
      end else begin
        m_st[k] = 0; m_match[k] = 0;
      end
    end else begin
      e = m_exp[k];
      m_exp[k] = nx(e);
      if (d == e) m_miss[k] = 0;
      else begin
`ifdef LFSR_CHK_BITERR_EN
        inc = pop(d ^ e);
`else
        inc = 1;
`endif
        m_pulse[k] = 1;
        m_cnt[k] = (m_cnt[k] + inc > m_max[k]) ? m_max[k] : m_cnt[k] + inc;
        m_miss[k]++;
        if (m_miss[k] == 3) begin m_st[k] = 0; m_miss[k] = 0; end
      end
    end
  endtask

  // One clock: drive at negedge, update model at posedge, compare just after
  task automatic cycle(input logic r, input logic v, input logic [9:0] d);
    @(negedge clk);
    rst = r; data_valid = v; data_in = d;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check("a_state", int'(st_a), m_st[0]);
    check("a_locked", int'(locked_a), m_st[0] == 2 ? 1 : 0);
    check("a_err_pulse", int'(err_pulse_a), m_pulse[0]);
    check("a_err_count", int'(cnt_a), m_cnt[0]);
    check("b_state", int'(st_b), m_st[1]);
    check("b_locked", int'(locked_b), m_st[1] == 2 ? 1 : 0);
    check("b_err_pulse", int'(err_pulse_b), m_pulse[1]);
    check("b_err_count", int'(cnt_b), m_cnt[1]);
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b1, gen);
      gen = 10'(nx(int'(gen)));
    end
  endtask

  task automatic bad(input logic [9:0] mask);
    cycle(1'b0, 1'b1, gen ^ mask);
    gen = 10'(nx(int'(gen)));
  endtask

  initial begin
    int c0, exp3;
    logic noisy;
    m_max[0] = 65535;
    m_max[1] = 15;

    // Reset, zeros in SEARCH, then clean seed 001 locking on the 5th beat
    tbl[0]  = '{1'b1, 1'b0, 10'h000, 0, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 10'h000, 0, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b1, 10'h000, 0, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 10'h000, 0, 0, 0, 0};
    tbl[4]  = '{1'b0, 1'b0, 10'h3ff, 0, 0, 0, 0};
    tbl[5]  = '{1'b0, 1'b1, 10'h001, 1, 0, 0, 0};
    tbl[6]  = '{1'b0, 1'b1, 10'h002, 1, 0, 0, 0};
    tbl[7]  = '{1'b0, 1'b1, 10'h004, 1, 0, 0, 0};
    tbl[8]  = '{1'b0, 1'b1, 10'h008, 1, 0, 0, 0};
    tbl[9]  = '{1'b0, 1'b1, 10'h010, 2, 1, 0, 0};
    tbl[10] = '{1'b0, 1'b1, 10'h020, 2, 1, 0, 0};
    tbl[11] = '{1'b0, 1'b1, 10'h040, 2, 1, 0, 0};
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].d);
      check("tbl_state", int'(st_a), tbl[i].st);
      check("tbl_locked", int'(locked_a), tbl[i].lk);
      check("tbl_err_pulse", int'(err_pulse_a), tbl[i].ep);
      check("tbl_err_count", int'(cnt_a), tbl[i].cnt);
    end
    gen = 10'h081;

    // Long clean run stays error-free
    clean(1023);
    check("clean_locked", int'(locked_a), 1);
    check("clean_count", int'(cnt_a), 0);

    // Single-bit error, then 3-bit error
    bad(10'h001);
    check("bit0_pulse", int'(err_pulse_a), 1);
    check("bit0_count", int'(cnt_a), 1);
    clean(1);
    check("bit0_pulse_clear", int'(err_pulse_a), 0);
    check("bit0_still_locked", int'(locked_a), 1);
    check("bit0_count_hold", int'(cnt_a), 1);
    bad(10'h007);
`ifdef LFSR_CHK_BITERR_EN
    exp3 = 4;
`else
    exp3 = 2;
`endif
    check("bit3_count", int'(cnt_a), exp3);
    clean(2);

    // Three consecutive bad words lose lock; clean stream relocks after 5 beats
    c0 = int'(cnt_a);
    bad(10'h001);
    bad(10'h001);
    check("loss_not_yet", int'(locked_a), 1);
    bad(10'h001);
    check("loss_locked", int'(locked_a), 0);
    check("loss_state", int'(st_a), 0);
    check("loss_count", int'(cnt_a), c0 + 3);
    clean(4);
    check("relock_pending", int'(locked_a), 0);
    clean(1);
    check("relock_locked", int'(locked_a), 1);
    check("relock_count", int'(cnt_a), c0 + 3);

    // Zeros while searching, then half-rate valid
    cycle(1'b1, 1'b0, 10'h000);
    cycle(1'b1, 1'b0, 10'h000);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 10'h000);
    check("zero_state", int'(st_a), 0);
    check("zero_locked", int'(locked_a), 0);
    check("zero_count", int'(cnt_a), 0);
    gen = 10'h155;
    for (int i = 0; i < 5; i++) begin
      clean(1);
      check("half_rate_lock", int'(locked_a), i == 4 ? 1 : 0);
      cycle(1'b0, 1'b0, 10'($urandom_range(0, 1023)));
    end
    check("half_rate_hold", int'(locked_a), 1);

    // Seven errors then reset mid-LOCKED
    clean(2);
    for (int i = 0; i < 7; i++) begin bad(10'h001); clean(1); end
    check("seven_count", int'(cnt_a), 7);
    cycle(1'b1, 1'b0, 10'h000);
    check("rst_locked", int'(locked_a), 0);
    check("rst_state", int'(st_a), 0);
    check("rst_count", int'(cnt_a), 0);

    // Saturation of the 4-bit instance
    clean(5);
    check("sat_locked", int'(locked_b), 1);
    for (int i = 0; i < 20; i++) begin bad(10'h001); clean(1); end
    check("sat_count_b", int'(cnt_b), 15);
    check("sat_count_a", int'(cnt_a), 20);
    clean(3);
    check("sat_hold_b", int'(cnt_b), 15);

    // Random stream against the model, alternating quiet and noisy phases
    cycle(1'b1, 1'b0, 10'h000);
    gen = 10'h2a5;
    noisy = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      int x;
      logic r, v;
      logic [9:0] d;
      if (i % 250 == 0) noisy = ~noisy;
      r = ($urandom_range(0, 599) == 0);
      v = ($urandom_range(0, 3) != 0);
      x = int'($urandom_range(0, 99));
      if (x < 3) gen = 10'($urandom_range(1, 1023));
      if (x >= 3 && x < 6) d = 10'h000;
      else if (x < (noisy ? 45 : 10)) d = gen ^ 10'($urandom_range(1, 1023));
      else d = gen;
      cycle(r, v, d);
      if (v) gen = 10'(nx(int'(gen)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
